// File: rtl/if_fetch.sv
// Instruction-fetch requester: issues one SRAM read per PC value, hands the
// instruction to IF/ID and holds the PC via stall_req until delivery.
module if_fetch #(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 16,
  parameter logic [DATA_W-1:0]  NOP_INST    = 16'h0800,
  parameter int                 ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_flag_o,
  input  logic              stall,
  input  logic              mem_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              stall_req,
  output logic              fetch_err
);

  localparam int               CNT_W   = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic                fetch_err_q, fetch_err_d;
  logic                kill_q, kill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                good_ack;

  // A delivery counts only if no redirect was seen during this fetch.
  assign good_ack = (state_q == REQ) && mem_ack && !kill_q && !branch_flag_o;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    req_pc_d     = req_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = 1'b0;
    kill_d       = kill_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        inst_valid_d = 1'b0;
        if (!mem_busy) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
          req_pc_d   = pc;
          kill_d     = 1'b0;
          cnt_d      = '0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (good_ack) begin
            inst_d       = mem_rdata;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = stall ? HOLD : IDLE;
          end else begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end else if (cnt_q == CNT_MAX) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          // The request stays on the bus after a redirect; its data is dropped later.
          cnt_d = cnt_q + 1'b1;
          if (branch_flag_o) kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_flag_o) begin
          state_d      = IDLE;
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
        end else if (!stall) begin
          state_d      = IDLE;
          inst_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      req_pc_q     <= '0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      kill_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      req_pc_q     <= req_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      kill_q       <= kill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;
  assign stall_req  = ~good_ack;

endmodule

// File: tb/tb_if_fetch.sv
// Scenario bench for if_fetch: a scoreboard queue holds each instruction the
// bench acks as deliverable; deliveries are popped and compared on inst_valid.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0;
  logic        branch_flag_o = 1'b0;
  logic        stall = 1'b0;
  logic        mem_busy = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        stall_req;
  logic        fetch_err;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } fetch_t;

  fetch_t sb[$];
  fetch_t exp;
  int     nChecks = 0;
  int     nFail   = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .branch_flag_o(branch_flag_o),
    .stall(stall), .mem_busy(mem_busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .stall_req(stall_req), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    tick(); tick();
    nChecks++; if (mem_req !== 1'b0) begin nFail++; $display("[TB] FAIL rst_req: mem_req=%b expected 0", mem_req); end
    nChecks++; if (inst !== 16'h0800) begin nFail++; $display("[TB] FAIL rst_inst: inst=%h expected 0800", inst); end
    nChecks++; if (inst_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_valid: inst_valid=%b expected 0", inst_valid); end
    nChecks++; if (stall_req !== 1'b1) begin nFail++; $display("[TB] FAIL rst_stall_req: stall_req=%b expected 1", stall_req); end
    nChecks++; if ({mem_addr, inst_pc, fetch_err} !== 33'h0) begin nFail++; $display("[TB] FAIL rst_misc: mem_addr=%h inst_pc=%h fetch_err=%b expected 0", mem_addr, inst_pc, fetch_err); end
    rst = 1'b1;
    tick();
    nChecks++; if (mem_req !== 1'b0) begin nFail++; $display("[TB] FAIL busy_park: mem_req=%b expected 0", mem_req); end
  endtask

  task automatic test_basic();
    pc = 16'h0000; mem_busy = 1'b0;
    tick();
    nChecks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin nFail++; $display("[TB] FAIL basic_issue: req=%b addr=%h expected 1/0000", mem_req, mem_addr); end
    mem_busy = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h4801;
    sb.push_back('{pc: 16'h0000, data: 16'h4801});
    #1;
    nChecks++; if (stall_req !== 1'b0) begin nFail++; $display("[TB] FAIL basic_stall_req: stall_req=%b expected 0", stall_req); end
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if (sb.size() == 0) begin nFail++; $display("[TB] FAIL basic_sb: scoreboard empty"); end
    else begin
      exp = sb.pop_front();
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp.pc, exp.data}) begin nFail++; $display("[TB] FAIL basic_deliver: v=%b pc=%h inst=%h expected 1/%h/%h", inst_valid, inst_pc, inst, exp.pc, exp.data); end
    end
    nChecks++; if ({mem_req, stall_req} !== 2'b01) begin nFail++; $display("[TB] FAIL basic_after: req=%b stall_req=%b expected 0/1", mem_req, stall_req); end
    tick();
    nChecks++; if (inst_valid !== 1'b0) begin nFail++; $display("[TB] FAIL basic_pulse: inst_valid=%b expected 0", inst_valid); end
  endtask

  task automatic test_hold();
    pc = 16'h0002; mem_busy = 1'b0;
    tick();
    nChecks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0002}) begin nFail++; $display("[TB] FAIL hold_issue: req=%b addr=%h expected 1/0002", mem_req, mem_addr); end
    mem_busy = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hABCD; stall = 1'b1;
    sb.push_back('{pc: 16'h0002, data: 16'hABCD});
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if (sb.size() == 0) begin nFail++; $display("[TB] FAIL hold_sb: scoreboard empty"); end
    else exp = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp.pc, exp.data}) begin nFail++; $display("[TB] FAIL hold_stable%0d: v=%b pc=%h inst=%h expected 1/%h/%h", i, inst_valid, inst_pc, inst, exp.pc, exp.data); end
      if (i < 2) tick();
    end
    stall = 1'b0; mem_busy = 1'b0; pc = 16'h0004;
    tick();
    nChecks++; if ({inst_valid, mem_req} !== 2'b00) begin nFail++; $display("[TB] FAIL hold_release: v=%b req=%b expected 0/0", inst_valid, mem_req); end
    tick();
    nChecks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0004}) begin nFail++; $display("[TB] FAIL hold_next_req: req=%b addr=%h expected 1/0004", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h1111; mem_busy = 1'b1;
    sb.push_back('{pc: 16'h0004, data: 16'h1111});
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if (sb.size() == 0) begin nFail++; $display("[TB] FAIL b2b_sb: scoreboard empty"); end
    else begin
      exp = sb.pop_front();
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp.pc, exp.data}) begin nFail++; $display("[TB] FAIL b2b_deliver: v=%b pc=%h inst=%h expected 1/%h/%h", inst_valid, inst_pc, inst, exp.pc, exp.data); end
    end
    tick();
  endtask

  task automatic test_branch();
    pc = 16'h0004; mem_busy = 1'b0;
    tick();
    nChecks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0004}) begin nFail++; $display("[TB] FAIL br_issue: req=%b addr=%h expected 1/0004", mem_req, mem_addr); end
    mem_busy = 1'b1; branch_flag_o = 1'b1; pc = 16'h000A;
    tick();
    branch_flag_o = 1'b0;
    nChecks++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 16'h0004, 1'b0}) begin nFail++; $display("[TB] FAIL br_keep_req: req=%b addr=%h v=%b expected 1/0004/0", mem_req, mem_addr, inst_valid); end
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    #1;
    nChecks++; if (stall_req !== 1'b1) begin nFail++; $display("[TB] FAIL br_stall_req: stall_req=%b expected 1", stall_req); end
    tick();
    mem_ack = 1'b0; mem_busy = 1'b0;
    nChecks++; if ({inst_valid, inst, mem_req} !== {1'b0, 16'h0800, 1'b0}) begin nFail++; $display("[TB] FAIL br_discard: v=%b inst=%h req=%b expected 0/0800/0", inst_valid, inst, mem_req); end
    tick();
    nChecks++; if ({mem_req, mem_addr} !== {1'b1, 16'h000A}) begin nFail++; $display("[TB] FAIL br_new_addr: req=%b addr=%h expected 1/000A", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h5555; mem_busy = 1'b1;
    sb.push_back('{pc: 16'h000A, data: 16'h5555});
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if (sb.size() == 0) begin nFail++; $display("[TB] FAIL br_sb: scoreboard empty"); end
    else begin
      exp = sb.pop_front();
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp.pc, exp.data}) begin nFail++; $display("[TB] FAIL br_deliver: v=%b pc=%h inst=%h expected 1/%h/%h", inst_valid, inst_pc, inst, exp.pc, exp.data); end
    end
    tick();
  endtask

  task automatic test_busy();
    pc = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++; if ({mem_req, stall_req} !== 2'b01) begin nFail++; $display("[TB] FAIL busy_idle%0d: req=%b stall_req=%b expected 0/1", i, mem_req, stall_req); end
    end
    mem_busy = 1'b0;
    tick();
    nChecks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0020}) begin nFail++; $display("[TB] FAIL busy_issue: req=%b addr=%h expected 1/0020", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h2222; mem_busy = 1'b1;
    sb.push_back('{pc: 16'h0020, data: 16'h2222});
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if (sb.size() == 0) begin nFail++; $display("[TB] FAIL busy_sb: scoreboard empty"); end
    else begin
      exp = sb.pop_front();
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp.pc, exp.data}) begin nFail++; $display("[TB] FAIL busy_deliver: v=%b pc=%h inst=%h expected 1/%h/%h", inst_valid, inst_pc, inst, exp.pc, exp.data); end
    end
    tick();
  endtask

  task automatic test_timeout();
    pc = 16'h0030; mem_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nChecks++; if ({mem_req, fetch_err} !== 2'b10) begin nFail++; $display("[TB] FAIL to_wait%0d: req=%b err=%b expected 1/0", i, mem_req, fetch_err); end
    end
    tick();
    nChecks++; if ({mem_req, fetch_err} !== 2'b01) begin nFail++; $display("[TB] FAIL to_abort: req=%b err=%b expected 0/1", mem_req, fetch_err); end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    nChecks++; if (stall_req !== 1'b1) begin nFail++; $display("[TB] FAIL to_late_stall_req: stall_req=%b expected 1", stall_req); end
    tick();
    mem_ack = 1'b0;
    nChecks++; if ({fetch_err, mem_req, mem_addr, inst_valid} !== {1'b0, 1'b1, 16'h0030, 1'b0}) begin nFail++; $display("[TB] FAIL to_rereq: err=%b req=%b addr=%h v=%b expected 0/1/0030/0", fetch_err, mem_req, mem_addr, inst_valid); end
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h3333; mem_busy = 1'b1;
    sb.push_back('{pc: 16'h0030, data: 16'h3333});
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if (sb.size() == 0) begin nFail++; $display("[TB] FAIL to_sb: scoreboard empty"); end
    else begin
      exp = sb.pop_front();
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp.pc, exp.data}) begin nFail++; $display("[TB] FAIL to_deliver: v=%b pc=%h inst=%h expected 1/%h/%h", inst_valid, inst_pc, inst, exp.pc, exp.data); end
    end
    tick();
  endtask

  task automatic test_async_reset();
    pc = 16'h0040; mem_busy = 1'b0;
    tick();
    nChecks++; if (mem_req !== 1'b1) begin nFail++; $display("[TB] FAIL ar_issue: req=%b expected 1", mem_req); end
    mem_busy = 1'b1;
    #2 rst = 1'b0;
    #1;
    nChecks++; if ({mem_req, inst_valid, stall_req, mem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin nFail++; $display("[TB] FAIL ar_req: req=%b v=%b stall_req=%b addr=%h expected 0/0/1/0000", mem_req, inst_valid, stall_req, mem_addr); end
    tick();
    rst = 1'b1; pc = 16'h0050; mem_busy = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h6666; stall = 1'b1; mem_busy = 1'b1;
    sb.push_back('{pc: 16'h0050, data: 16'h6666});
    tick();
    mem_ack = 1'b0;
    nChecks++;
    if (sb.size() == 0) begin nFail++; $display("[TB] FAIL ar_sb: scoreboard empty"); end
    else begin
      exp = sb.pop_front();
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp.pc, exp.data}) begin nFail++; $display("[TB] FAIL ar_deliver: v=%b pc=%h inst=%h expected 1/%h/%h", inst_valid, inst_pc, inst, exp.pc, exp.data); end
    end
    #2 rst = 1'b0;
    #1;
    nChecks++; if ({inst_valid, inst, inst_pc} !== {1'b0, 16'h0800, 16'h0000}) begin nFail++; $display("[TB] FAIL ar_hold: v=%b inst=%h pc=%h expected 0/0800/0000", inst_valid, inst, inst_pc); end
    tick();
    rst = 1'b1; stall = 1'b0;
    tick();
    nChecks++; if (sb.size() != 0) begin nFail++; $display("[TB] FAIL sb_empty: %0d entries left expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_branch();
    test_busy();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
